axi_burst_master: RTL
=====================

# axi_burst_master

AXI4 initiator that drives the 128-bit, 28-bit-address memory slave port of the DRAM controller wrapper from a simple command/stream interface. It accepts one read or write command of up to 256 beats, splits it at 4 KB and MAX_BURST boundaries into INCR bursts, and moves data between the local streams and AXI. It sits in the `clk` domain in front of the wrapper's slave port, one transaction in flight at a time.

## Interface
- AXI_ID, default 4'h0: value driven on awid/arid; bid/rid are ignored.
- MAX_BURST, default 256: maximum beats per AXI burst; must be a power of two, 1..256.
- clk  in  1  sole clock.
- nrst  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  28  byte address; bits [3:0] ignored and treated as 0.
- cmd_len  in  9  total beats, 0..256.
- wr_data  in  128 ; wr_strb  in  16 ; wr_valid  in  1 ; wr_ready  out  1  write stream.
- rd_data  out  128 ; rd_valid  out  1 ; rd_last  out  1 ; rd_ready  in  1  read stream.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky response error; see Configuration.
- m_axi_aw{id[4],addr[28],len[8],size[3],burst[2],lock[1],cache[4],prot[3],qos[4],valid}  out ; m_axi_awready  in.
- m_axi_w{data[128],strb[16],last,valid}  out ; m_axi_wready  in.
- m_axi_b{id[4],resp[2],valid}  in ; m_axi_bready  out.
- m_axi_ar{…same fields as AW…}  out ; m_axi_arready  in.
- m_axi_r{id[4],data[128],resp[2],last,valid}  in ; m_axi_rready  out.

## Operation
- Fixed fields: size 3'b100 (16 B), burst INCR, lock 0, cache 4'b0011, prot 0, qos 0.
- States: IDLE, AW, W, B, AR, R.
- IDLE: cmd_ready = 1. When cmd_valid is high, the block latches addr and remaining = cmd_len and clears err.
  - cmd_len = 0: done pulses the next cycle and the block stays in IDLE. No AXI traffic.
  - cmd_len > 0: go to AW if cmd_write, otherwise AR.
- chunk = min(remaining, MAX_BURST, 256 − addr[11:4]); axlen = chunk − 1.
- AW / AR: hold awvalid/arvalid and the address fields stable until ready is sampled high. Then go to W or R.
- W: m_axi_wvalid = wr_valid; wr_ready = m_axi_wready; data and strb pass through combinationally. A beat counter asserts wlast on beat chunk − 1. After the last handshake, go to B.
- B: bready = 1. On bvalid: remaining −= chunk; addr += chunk × 16 (modulo 2^28). If remaining = 0, pulse done and go to IDLE; otherwise go to AW.
- R: rd_valid = m_axi_rvalid; m_axi_rready = rd_ready; rd_data passes through. rd_last = rlast on the final chunk only.
  - The transition on rlast updates remaining and addr exactly as in B, then goes to AR, or pulses done and goes to IDLE.
- The block never issues a new burst until the previous burst's response or last R beat has been received.

## Timing
- Reset values: all valids, bready, rready, cmd_ready, wr_ready, rd_valid, rd_last, done and err are 0. Address fields are 0. State is IDLE.
  - cmd_ready is 0 only during reset; it rises on the first clock after nrst is released.
- Command accept at cycle t: awvalid/arvalid is high at t+1 (registered).
- Burst boundaries:
  - Last B handshake at cycle t: next awvalid is at t+1.
  - Last R beat at cycle t: next arvalid is at t+1.
  - Final burst: done is high at t+1 and cmd_ready is high at t+1.
- Stream stalls: wr_valid low or rd_ready low stalls AXI beat-for-beat with no buffering; zero added latency.
- Reset mid-transaction: outputs drop immediately (asynchronous). The in-flight AXI transaction is abandoned; the slave must be reset together with this block.

## Configuration
- AXI_BURST_MASTER_ERR_EN defined:
  - err is set when bresp ≠ 2'b00 on a handshake, or rresp ≠ 2'b00 on any R beat.
  - err holds until the next command accept.
  - Data continues to flow and bursts still complete.
- AXI_BURST_MASTER_ERR_EN undefined: resp fields are ignored and err is tied to 0.

## Structure
- Package axi_master_pkg holds:
  - the state enum;
  - AXI_SIZE_16B, AXI_BURST_INCR, AXI_RESP_OKAY;
  - ADDR_W = 28, DATA_W = 128, STRB_W = 16, ID_W = 4.
- One sub-module, axi_burst_split: combinational chunk/axlen computation from addr, remaining and MAX_BURST.

## Test plan
- Write cmd addr 0x0000100, len 4, slave always ready → one AW (addr 0x0000100, len 3); 4 W beats with wlast on the 4th; B OKAY; done 1 cycle later.
- Read cmd addr 0x0000FE0, len 4 → AR addr 0x0000FE0 len 1, then AR addr 0x0001000 len 1; rd_last only on the 4th beat; done once.
- Write len 256 with MAX_BURST = 64 → four AW at +0x400 steps, each len 63; random wready/wr_valid stalls; data matches in order.
- cmd_len 0 → no AXI valid is ever asserted; done pulses at t+1.
- With AXI_BURST_MASTER_ERR_EN, return rresp 2'b10 on beat 2 of 3 → err = 1 after that beat, held until the next cmd accept; all 3 beats are delivered.
- Assert nrst low during W beat 2 → all valids are 0 in the same cycle; after release, a new read cmd completes normally.

Source files
------------

// File: rtl/axi_master_pkg.sv
// axi_master_pkg: shared FSM state type, fixed AXI encodings and bus widths
// for axi_burst_master and axi_burst_split.
package axi_master_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int STRB_W = 16;
  localparam int ID_W   = 4;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } state_e;

endpackage

// File: rtl/axi_burst_split.sv
// axi_burst_split: size of the next INCR burst, limited by beats remaining,
// MAX_BURST and the 4 KB page. In: addr_blk (addr[11:4]), remaining. Out: chunk, axlen.
module axi_burst_split
  import axi_master_pkg::*;
#(
  parameter int MAX_BURST = 256
) (
  input  logic [7:0] addr_blk,
  input  logic [8:0] remaining,
  output logic [8:0] chunk,
  output logic [7:0] axlen
);

  localparam logic [8:0] MAXB = 9'(MAX_BURST);

  logic [8:0] to_4k;
  logic [8:0] lim;

  always_comb begin
    to_4k = 9'd256 - {1'b0, addr_blk};
    lim   = (MAXB < to_4k) ? MAXB : to_4k;
    chunk = (remaining < lim) ? remaining : lim;
    axlen = 8'(chunk - 9'd1);
  end

endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4 initiator splitting one read/write command into INCR
// bursts. Ports: cmd_*, wr_* / rd_* streams, done, err, m_axi_* (AW/W/B/AR/R).
// Define AXI_BURST_MASTER_ERR_EN to enable the sticky response error flag.
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID    = 4'h0,
  parameter int              MAX_BURST = 256
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [8:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              done,
  output logic              err,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic [3:0]        m_axi_awqos,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic [7:0]        beat_q, beat_d;
  logic              done_q, done_d;
  logic              live_q;
  logic              err_clr;
  logic              burst_done;
  logic              last_chunk;
  logic [8:0]        chunk;
  logic [7:0]        axlen;
  logic [7:0]        len_out;

  axi_burst_split #(
    .MAX_BURST (MAX_BURST)
  ) u_split (
    .addr_blk  (addr_q[11:4]),
    .remaining (rem_q),
    .chunk     (chunk),
    .axlen     (axlen)
  );

  assign last_chunk = (rem_q == chunk);
  // Keep the length field at 0 whenever nothing is pending.
  assign len_out    = (rem_q == 9'd0) ? 8'd0 : axlen;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_out;
  assign m_axi_awsize  = AXI_SIZE_16B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_BUF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'h0;

  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_out;
  assign m_axi_arsize  = AXI_SIZE_16B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_BUF;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'h0;

  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign rd_data     = m_axi_rdata;
  assign done        = done_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    beat_d        = beat_q;
    done_d        = 1'b0;
    err_clr       = 1'b0;
    burst_done    = 1'b0;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          addr_d  = {cmd_addr[ADDR_W-1:4], 4'h0};
          rem_d   = cmd_len;
          err_clr = 1'b1;
          if (cmd_len == 9'd0) begin
            done_d = 1'b1;
          end else if (cmd_write) begin
            state_d = ST_AW;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (beat_q == axlen);
        if (wr_valid && m_axi_wready) begin
          if (m_axi_wlast) begin
            beat_d  = 8'd0;
            state_d = ST_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        burst_done   = m_axi_bvalid;
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        rd_last      = m_axi_rlast && last_chunk;
        burst_done   = m_axi_rvalid && rd_ready && m_axi_rlast;
      end
      default: state_d = ST_IDLE;
    endcase
    // Retire a burst: advance the window, then either finish or issue the next.
    if (burst_done) begin
      rem_d  = rem_q - chunk;
      addr_d = addr_q + ADDR_W'({chunk, 4'h0});
      if (last_chunk) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = (state_q == ST_B) ? ST_AW : ST_AR;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      live_q  <= 1'b1;
    end
  end

`ifdef AXI_BURST_MASTER_ERR_EN
  logic err_q, err_d;
  logic unused_ids;

  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (state_q == ST_B && m_axi_bvalid
        && m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
    if (state_q == ST_R && m_axi_rvalid && rd_ready
        && m_axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_resp;

  assign unused_resp = ^{m_axi_bid, m_axi_rid, m_axi_bresp,
                         m_axi_rresp, err_clr};
  assign err = 1'b0;
`endif

endmodule
